// File: rtl/ex_mem_stage_pkg.sv
// Shared CPU package: opcodes, control/flag bit positions and the EX/MEM payload.
package ex_mem_stage_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CTRL_W  = 5;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned FLAG_W  = 3;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned OP_MSB  = 15;

    typedef enum logic [OP_W-1:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_RED    = 4'b0010,
        OP_XOR    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRA    = 4'b0101,
        OP_ROR    = 4'b0110,
        OP_PADDSB = 4'b0111,
        OP_LW     = 4'b1000,
        OP_SW     = 4'b1001,
        OP_LHB    = 4'b1010,
        OP_LLB    = 4'b1011,
        OP_B      = 4'b1100,
        OP_BR     = 4'b1101,
        OP_PCS    = 4'b1110,
        OP_HLT    = 4'b1111
    } opcode_e;

    // ctrl = {RegWrite, MemRead, MemWrite, MemToReg, Halt}
    localparam int unsigned CTRL_REGWRITE = 4;
    localparam int unsigned CTRL_MEMREAD  = 3;
    localparam int unsigned CTRL_MEMWRITE = 2;
    localparam int unsigned CTRL_MEMTOREG = 1;
    localparam int unsigned CTRL_HALT     = 0;

    // flags = {Z, V, N}
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [DATA_W-1:0]  alu_out;
        logic [DATA_W-1:0]  store_data;
        logic [CTRL_W-1:0]  ctrl;
        logic [REG_W-1:0]   wreg;
    } mem_reg_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX/MEM pipeline bus: EX-side inputs, pipeline controls and MEM-side outputs.
interface ex_mem_stage_if;
    import ex_mem_stage_pkg::*;

    logic               stall;
    logic               flush;
    logic               valid_EX;
    logic [INSTR_W-1:0] instr_EX;
    logic [DATA_W-1:0]  alu_out_EX;
    logic               alu_v_EX;
    logic [DATA_W-1:0]  store_data_EX;
    logic [CTRL_W-1:0]  ctrl_EX;
    logic [REG_W-1:0]   wreg_EX;

    logic               valid_MEM;
    logic [INSTR_W-1:0] instr_MEM;
    logic [DATA_W-1:0]  alu_out_MEM;
    logic [DATA_W-1:0]  store_data_MEM;
    logic [CTRL_W-1:0]  ctrl_MEM;
    logic [REG_W-1:0]   wreg_MEM;
    logic [FLAG_W-1:0]  flags;
    logic [FLAG_W-1:0]  flags_fwd;
    logic               halted;

    modport master (
        output stall, flush, valid_EX, instr_EX, alu_out_EX, alu_v_EX,
               store_data_EX, ctrl_EX, wreg_EX,
        input  valid_MEM, instr_MEM, alu_out_MEM, store_data_MEM, ctrl_MEM,
               wreg_MEM, flags, flags_fwd, halted
    );

    modport slave (
        input  stall, flush, valid_EX, instr_EX, alu_out_EX, alu_v_EX,
               store_data_EX, ctrl_EX, wreg_EX,
        output valid_MEM, instr_MEM, alu_out_MEM, store_data_MEM, ctrl_MEM,
               wreg_MEM, flags, flags_fwd, halted
    );

endinterface

// File: rtl/ex_mem_stage_flag_reg.sv
// Condition-flag register {Z,V,N} with opcode-dependent update.
// FLAG_BYPASS_EN: flags_fwd shows the next-edge flag value instead of the register.
module flag_reg
    import ex_mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              update_en,
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_v,
    output logic [FLAG_W-1:0] flags,
    output logic [FLAG_W-1:0] flags_fwd
);

    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_nxt;
    logic              zero;

    assign zero = (alu_out == DATA_W'(0));

    // Arithmetic ops set all flags, logic/shift ops only Z, everything else holds.
    always_comb begin
        flags_nxt = flags_q;
        if (update_en) begin
            case (opcode_e'(opcode))
                OP_ADD, OP_SUB: begin
                    flags_nxt[FLAG_Z] = zero;
                    flags_nxt[FLAG_V] = alu_v;
                    flags_nxt[FLAG_N] = alu_out[DATA_W-1];
                end
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_nxt[FLAG_Z] = zero;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) flags_q <= '0;
        else     flags_q <= flags_nxt;
    end

    assign flags = flags_q;

`ifdef FLAG_BYPASS_EN
    assign flags_fwd = flags_nxt;
`else
    assign flags_fwd = flags_q;
`endif

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with stall/flush, sticky halt and condition flags.
// FLAG_BYPASS_EN (in flag_reg) selects bypassed flags_fwd.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
(
    input  logic clk,
    input  logic rst,
    ex_mem_stage_if.slave bus
);

    mem_reg_t mem_q;
    logic     halted_q;
    logic     capture;

    // Priority: rst > halted (freeze) > flush (bubble) > stall (hold) > capture.
    assign capture = !halted_q && !bus.flush && !bus.stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            if (bus.flush) begin
                mem_q <= '0;
            end else if (!bus.stall) begin
                mem_q.valid      <= bus.valid_EX;
                mem_q.instr      <= bus.instr_EX;
                mem_q.alu_out    <= bus.alu_out_EX;
                mem_q.store_data <= bus.store_data_EX;
                mem_q.ctrl       <= bus.valid_EX ? bus.ctrl_EX : CTRL_W'(0);
                mem_q.wreg       <= bus.wreg_EX;
                if (bus.valid_EX && bus.ctrl_EX[CTRL_HALT]) halted_q <= 1'b1;
            end
        end
    end

    flag_reg u_flag_reg (
        .clk       (clk),
        .rst       (rst),
        .update_en (capture && bus.valid_EX),
        .opcode    (bus.instr_EX[OP_MSB -: OP_W]),
        .alu_out   (bus.alu_out_EX),
        .alu_v     (bus.alu_v_EX),
        .flags     (bus.flags),
        .flags_fwd (bus.flags_fwd)
    );

    assign bus.valid_MEM      = mem_q.valid;
    assign bus.instr_MEM      = mem_q.instr;
    assign bus.alu_out_MEM    = mem_q.alu_out;
    assign bus.store_data_MEM = mem_q.store_data;
    assign bus.ctrl_MEM       = mem_q.ctrl;
    assign bus.wreg_MEM       = mem_q.wreg;
    assign bus.halted         = halted_q;

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port stall  in  1  hold all MEM-side state this cycle.
REQ-004 SHALL have port flush  in  1  load a bubble into MEM this cycle.
REQ-005 SHALL have port valid_EX  in  1  EX holds a real instruction.
REQ-006 SHALL have port instr_EX  in  16  EX instruction word; opcode is [15:12].
REQ-007 SHALL have port alu_out_EX  in  16  ALU result.
REQ-008 SHALL have port alu_v_EX  in  1  ALU signed overflow for ADD/SUB.
REQ-009 SHALL have port store_data_EX  in  16  forwarded RegData2 for SW.
REQ-010 SHALL have port ctrl_EX  in  5  {RegWrite, MemRead, MemWrite, MemToReg, Halt}.
REQ-011 SHALL have port wreg_EX  in  4  destination register.
REQ-012 SHALL have ports valid_MEM, instr_MEM, alu_out_MEM, store_data_MEM, ctrl_MEM, wreg_MEM  out  widths as above  registered copies.
REQ-013 SHALL have port flags  out  3  registered {Z, V, N}.
REQ-014 SHALL have port flags_fwd  out  3  flags as seen by a branch resolving this cycle.
REQ-015 SHALL have port halted  out  1  sticky; set once a Halt reaches MEM.

Function
REQ-016 SHALL capture every EX field into its MEM register on each edge with stall=0, flush=0; latency exactly 1 cycle.
REQ-017 SHALL hold every MEM register and flags unchanged when stall=1, flush=0.
REQ-018 SHALL load a bubble when flush=1: valid_MEM=0, ctrl_MEM=0, other data fields 0; flush overrides stall.
REQ-019 SHALL force ctrl_MEM=0 whenever valid_EX=0 is captured; data fields pass through.
REQ-020 SHALL update flags only on a capture edge (no stall, no flush) with valid_EX=1.
REQ-021 SHALL, for opcode 0000 ADD and 0001 SUB: Z=(alu_out_EX==0), V=alu_v_EX, N=alu_out_EX[15].
REQ-022 SHALL, for opcodes 0011 XOR, 0100 SLL, 0101 SRA, 0110 ROR: update Z only; V, N held.
REQ-023 SHALL leave all flags unchanged for every other opcode (RED, PADDSB, LW, SW, LHB, LLB, B, BR, PCS, HLT).
REQ-024 SHALL set halted on the edge capturing a valid instruction with Halt=1; cleared only by rst.
REQ-025 SHALL, once halted=1, treat every later edge as stall (MEM registers and flags frozen) regardless of inputs.
REQ-026 SHALL produce all outputs from registers except flags_fwd.

Reset
REQ-027 SHALL, on rst=1 at an edge, clear valid_MEM, instr_MEM, alu_out_MEM, store_data_MEM, ctrl_MEM, wreg_MEM, flags (3'b000) and halted; rst overrides stall, flush and halted.
REQ-028 SHALL drop any instruction in flight when rst asserts mid-operation; first capture occurs on the first edge with rst=0.

Configuration
REQ-029 SHALL, with FLAG_BYPASS_EN defined, drive flags_fwd combinationally with the value flags will take at the next edge (REQ-020..023 applied to current EX inputs, gated by stall/flush/halted).
REQ-030 SHALL, without FLAG_BYPASS_EN, drive flags_fwd = flags; the hazard unit then stalls branches one cycle behind flag-setting instructions.

Structure
REQ-031 SHALL take opcode constants (ADD..HLT), ctrl bit indices and flag bit indices from the shared CPU package, also used by the decoder and ALU control.
REQ-032 SHALL place flag next-state logic and the flag register in one sub-module, flag_reg, instantiated once.

Verification
REQ-033 SHALL cover: ADD with alu_out_EX=16'h0000, alu_v_EX=1 -> next edge flags=3'b110, alu_out_MEM=0, latency 1.
REQ-034 SHALL cover: flags=3'b011, then XOR result 16'h0000 -> flags=3'b111; then PADDSB result 0 -> flags remain 3'b111.
REQ-035 SHALL cover: SUB result 16'h8001 with stall=1 for 2 cycles -> MEM and flags unchanged; on release flags=3'b001.
REQ-036 SHALL cover: stall=1 and flush=1 together with LW in EX -> valid_MEM=0, ctrl_MEM=0, flags unchanged.
REQ-037 SHALL cover: HLT captured -> halted=1 next edge; a following ADD result 0 does not change flags; rst=1 -> all outputs 0.
REQ-038 SHALL cover: with FLAG_BYPASS_EN, SUB result 0 in EX -> flags_fwd[Z]=1 same cycle, flags[Z]=1 next edge; without it flags_fwd tracks flags.
